// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready handshake and stalls EX until the access completes.
// Optional busy-timeout abort is enabled by defining MA_TIMEOUT_EN.
module mem_access_stage #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 16,
  parameter int                 REG_IDX_W = 5,
  parameter int                 CTRL_W    = 4,
  parameter logic [CTRL_W-1:0]  OP_LOAD   = CTRL_W'(4'b1100),
  parameter logic [CTRL_W-1:0]  OP_STORE  = CTRL_W'(4'b1110),
  parameter int                 TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_ex,
  input  logic [CTRL_W-1:0]    control_ex,
  input  logic [DATA_W-1:0]    result_ex,
  input  logic [DATA_W-1:0]    reg_data_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
  input  logic                 dest_reg_write_en_ex,
  output logic                 stall_ma,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ready,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 valid_ma,
  output logic [CTRL_W-1:0]    control_ma,
  output logic [DATA_W-1:0]    result_ma,
  output logic [DATA_W-1:0]    data_ma,
  output logic [REG_IDX_W-1:0] dest_reg_index_ma,
  output logic                 dest_reg_write_en_ma,
  output logic                 err_ma
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [CTRL_W-1:0]    ctrl_h;
  logic [DATA_W-1:0]    result_h;
  logic [DATA_W-1:0]    wdata_h;
  logic [REG_IDX_W-1:0] dest_idx_h;
  logic                 dest_we_h;
  logic                 mem_op;
  logic                 is_busy;

  assign mem_op  = valid_ex && ((control_ex == OP_LOAD) || (control_ex == OP_STORE));
  assign is_busy = (state == BUSY);

  // Memory-side outputs decode directly from the state register so reset drops them at once.
  assign stall_ma  = is_busy;
  assign mem_req   = is_busy;
  assign mem_we    = is_busy && (ctrl_h == OP_STORE);
  assign mem_addr  = is_busy ? result_h[ADDR_W-1:0] : '0;
  assign mem_wdata = is_busy ? wdata_h : '0;

`ifdef MA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             err_q;

  assign timed_out = is_busy && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err_ma    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state == IDLE) && mem_op) begin
      wait_cnt <= '0;
    end else if (is_busy && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign err_ma = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      ctrl_h               <= '0;
      result_h             <= '0;
      wdata_h              <= '0;
      dest_idx_h           <= '0;
      dest_we_h            <= 1'b0;
      valid_ma             <= 1'b0;
      control_ma           <= '0;
      result_ma            <= '0;
      data_ma              <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
`ifdef MA_TIMEOUT_EN
      err_q                <= 1'b0;
`endif
    end else begin
`ifdef MA_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_op) begin
            ctrl_h               <= control_ex;
            result_h             <= result_ex;
            wdata_h              <= reg_data_ex;
            dest_idx_h           <= dest_reg_index_ex;
            dest_we_h            <= dest_reg_write_en_ex;
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
            state                <= BUSY;
          end else begin
            valid_ma             <= valid_ex;
            control_ma           <= control_ex;
            result_ma            <= result_ex;
            data_ma              <= '0;
            dest_reg_index_ma    <= dest_reg_index_ex;
            dest_reg_write_en_ma <= valid_ex && dest_reg_write_en_ex;
          end
        end
        BUSY: begin
          // A ready on the final timeout cycle still completes the access normally.
          if (mem_ready) begin
            valid_ma             <= 1'b1;
            control_ma           <= ctrl_h;
            result_ma            <= result_h;
            data_ma              <= (ctrl_h == OP_LOAD) ? mem_rdata : '0;
            dest_reg_index_ma    <= dest_idx_h;
            dest_reg_write_en_ma <= dest_we_h;
            state                <= IDLE;
`ifdef MA_TIMEOUT_EN
          end else if (timed_out) begin
            valid_ma             <= 1'b1;
            control_ma           <= ctrl_h;
            result_ma            <= result_h;
            data_ma              <= '0;
            dest_reg_index_ma    <= dest_idx_h;
            dest_reg_write_en_ma <= 1'b0;
            err_q                <= 1'b1;
            state                <= IDLE;
`endif
          end else begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
